// File: rtl/symbol_pkg.sv
// symbol_pkg: symbol geometry shared by the 2-bit mux and the symbol packer
package symbol_pkg;
   localparam int SYM_W   = 2;
   localparam int SYMBOLS = 4;
   localparam int WORD_W  = SYM_W * SYMBOLS;
   localparam int CNT_W   = $clog2(SYMBOLS + 1);
   function automatic logic [WORD_W-1:0] left_align(input logic [WORD_W-1:0] w, input logic [CNT_W-1:0] n);
      return w << (SYM_W * (SYMBOLS - int'(n)));
   endfunction
endpackage

// File: rtl/symbol_packer.sv
// symbol_packer: packs consecutive symbols MSB-first into words behind a valid/ready output register
module symbol_packer
   import symbol_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [SYM_W-1:0]  data_in,
   output logic              ready_out,
   input  logic              flush,
   input  logic              ready_in,
   output logic              valid_out,
   output logic [WORD_W-1:0] data_out,
   output logic [CNT_W-1:0]  count_out
);
   logic [WORD_W-1:0] acc, shifted, load_word;
   logic [CNT_W-1:0]  cnt, load_cnt;
   logic              flush_pend, out_free, accept, complete, drain, part, load;
   assign ready_out = (cnt < CNT_W'(SYMBOLS)) && !flush_pend;
   assign out_free  = !valid_out || ready_in;
   assign accept    = valid_in && ready_out;
   assign shifted   = {acc[WORD_W-SYM_W-1:0], data_in};
   assign complete  = accept && cnt == CNT_W'(SYMBOLS - 1);
   assign drain     = cnt == CNT_W'(SYMBOLS);
   assign part      = flush_pend && cnt != '0 && cnt < CNT_W'(SYMBOLS);
   assign load      = out_free && (complete || drain || part);
   assign load_word = complete ? shifted : drain ? acc : left_align(acc, cnt);
   assign load_cnt  = (complete || drain) ? CNT_W'(SYMBOLS) : cnt;
   // accumulator, symbol count and pending flush; a full acc drains before a pending flush is served
   always_ff @(posedge clk) begin
      if (reset) begin
         acc        <= '0;
         cnt        <= '0;
         flush_pend <= 1'b0;
      end else begin
         if (accept) acc <= shifted;
         if (accept) cnt <= complete ? (out_free ? '0 : CNT_W'(SYMBOLS)) : cnt + CNT_W'(1);
         else if (load) cnt <= '0;
         flush_pend <= flush || (flush_pend && cnt != '0 && !(part && out_free));
      end
   end
   // output register: loads a new word when free, otherwise holds until the consumer takes it
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_out <= 1'b0;
         data_out  <= '0;
         count_out <= '0;
      end else if (load) begin
         valid_out <= 1'b1;
         data_out  <= load_word;
         count_out <= load_cnt;
      end else if (ready_in) begin
         valid_out <= 1'b0;
      end
   end
endmodule

// File: tb/tb_symbol_packer.sv
// tb_symbol_packer: directed and randomized checks of symbol_packer against a symbol-list scoreboard
module tb_symbol_packer;
   logic       clk = 0, reset = 1, valid_in = 0, flush = 0, ready_in = 0;
   logic [1:0] data_in = 0;
   logic       ready_out, valid_out;
   logic [7:0] data_out;
   logic [2:0] count_out;
   int         checks = 0, failures = 0;
   int         pend_q[$];
   logic [7:0] exp_w[$];
   int         exp_c[$];
   logic [1:0] s8 [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};

   symbol_packer dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .ready_out(ready_out),
      .flush(flush), .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out), .count_out(count_out)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout reached without finishing");
      $fatal(1);
   end

   // expected word: pending symbols placed first-in-MSBs, unused low symbols zero
   task automatic emit();
      logic [7:0] w = 8'h00;
      foreach (pend_q[i]) w = w | (8'(pend_q[i]) << (2 * (3 - i)));
      exp_w.push_back(w);
      exp_c.push_back(pend_q.size());
      pend_q.delete();
   endtask

   // one clock: observe handshakes before the edge, update scoreboard, then check hold after the edge
   task automatic cycle();
      logic acc_s, out_s, hold;
      logic [7:0] pd, w;
      logic [2:0] pc;
      int c;
      @(negedge clk);
      acc_s = valid_in && ready_out && !reset;
      out_s = valid_out && ready_in && !reset;
      hold  = valid_out && !ready_in && !reset;
      pd = data_out;
      pc = count_out;
      if (reset) begin
         pend_q.delete();
         exp_w.delete();
         exp_c.delete();
      end
      if (out_s) begin
         checks++;
         if (exp_w.size() == 0) begin
            failures++;
            $display("FAIL word_order got=%h/%0d expected=no word", data_out, count_out);
         end else begin
            w = exp_w.pop_front();
            c = exp_c.pop_front();
            if (data_out !== w || count_out !== 3'(c)) begin
               failures++;
               $display("FAIL word_value got=%h/%0d expected=%h/%0d", data_out, count_out, w, c);
            end
         end
      end
      if (acc_s) begin
         pend_q.push_back(int'(data_in));
         if (pend_q.size() == 4) emit();
      end
      if (flush && !reset && pend_q.size() > 0) emit();
      @(posedge clk);
      #1;
      if (hold) begin
         checks++;
         if (!valid_out || data_out !== pd || count_out !== pc) begin
            failures++;
            $display("FAIL hold got=%b/%h/%0d expected=1/%h/%0d", valid_out, data_out, count_out, pd, pc);
         end
      end
   endtask

   task automatic send(input logic [1:0] s);
      valid_in = 1;
      data_in  = s;
      cycle();
      valid_in = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      cycle();
      cycle();
      reset = 0;
      checks++;
      if (valid_out !== 0 || data_out !== 8'h00 || count_out !== 3'd0 || ready_out !== 1) begin
         failures++;
         $display("FAIL reset_state got=%b/%h/%0d/%b expected=0/00/0/1", valid_out, data_out, count_out, ready_out);
      end
   endtask

   task automatic test_single();
      ready_in = 1;
      send(2'd3);
      send(2'd1);
      send(2'd2);
      checks++;
      if (valid_out !== 0) begin
         failures++;
         $display("FAIL single_early got=%b expected=0", valid_out);
      end
      send(2'd0);
      checks++;
      if (valid_out !== 1 || data_out !== 8'hD8 || count_out !== 3'd4) begin
         failures++;
         $display("FAIL single_word got=%b/%h/%0d expected=1/d8/4", valid_out, data_out, count_out);
      end
      cycle();
      checks++;
      if (valid_out !== 0) begin
         failures++;
         $display("FAIL single_pulse got=%b expected=0", valid_out);
      end
   endtask

   task automatic test_stream();
      ready_in = 1;
      for (int i = 0; i < 8; i++) begin
         valid_in = 1;
         data_in  = s8[i];
         cycle();
         checks++;
         if (ready_out !== 1) begin
            failures++;
            $display("FAIL stream_ready i=%0d got=%b expected=1", i, ready_out);
         end
         if (i == 3 || i == 7) begin
            checks++;
            if (valid_out !== 1 || data_out !== (i == 3 ? 8'h1B : 8'hE4)) begin
               failures++;
               $display("FAIL stream_word i=%0d got=%b/%h expected=1/%h", i, valid_out, data_out, i == 3 ? 8'h1B : 8'hE4);
            end
         end
         if (i == 4) begin
            checks++;
            if (valid_out !== 0) begin
               failures++;
               $display("FAIL stream_gap got=%b expected=0", valid_out);
            end
         end
      end
      valid_in = 0;
      cycle();
   endtask

   task automatic test_backpressure();
      ready_in = 0;
      for (int i = 0; i < 8; i++) send(s8[i]);
      checks++;
      if (ready_out !== 0 || valid_out !== 1 || data_out !== 8'h1B) begin
         failures++;
         $display("FAIL bp_full got=%b/%b/%h expected=0/1/1b", ready_out, valid_out, data_out);
      end
      for (int i = 0; i < 2; i++) send(2'($urandom_range(0, 3)));
      checks++;
      if (ready_out !== 0 || data_out !== 8'h1B) begin
         failures++;
         $display("FAIL bp_stall got=%b/%h expected=0/1b", ready_out, data_out);
      end
      ready_in = 1;
      cycle();
      checks++;
      if (valid_out !== 1 || data_out !== 8'hE4 || count_out !== 3'd4 || ready_out !== 1) begin
         failures++;
         $display("FAIL bp_second got=%b/%h/%0d/%b expected=1/e4/4/1", valid_out, data_out, count_out, ready_out);
      end
      cycle();
      checks++;
      if (valid_out !== 0) begin
         failures++;
         $display("FAIL bp_drained got=%b expected=0", valid_out);
      end
   endtask

   task automatic test_flush();
      ready_in = 1;
      send(2'd1);
      send(2'd2);
      send(2'd3);
      flush = 1;
      cycle();
      flush = 0;
      checks++;
      if (ready_out !== 0 || valid_out !== 0) begin
         failures++;
         $display("FAIL flush_pend got=%b/%b expected=0/0", ready_out, valid_out);
      end
      cycle();
      checks++;
      if (valid_out !== 1 || data_out !== 8'h6C || count_out !== 3'd3 || ready_out !== 1) begin
         failures++;
         $display("FAIL flush_word got=%b/%h/%0d/%b expected=1/6c/3/1", valid_out, data_out, count_out, ready_out);
      end
      send(2'd0);
      send(2'd3);
      send(2'd0);
      send(2'd3);
      checks++;
      if (valid_out !== 1 || data_out !== 8'h33 || count_out !== 3'd4) begin
         failures++;
         $display("FAIL flush_realign got=%b/%h/%0d expected=1/33/4", valid_out, data_out, count_out);
      end
      cycle();
   endtask

   task automatic test_flush_empty();
      ready_in = 1;
      flush = 1;
      cycle();
      flush = 0;
      checks++;
      if (valid_out !== 0 || ready_out !== 0) begin
         failures++;
         $display("FAIL flush_empty_pend got=%b/%b expected=0/0", valid_out, ready_out);
      end
      cycle();
      checks++;
      if (valid_out !== 0 || ready_out !== 1) begin
         failures++;
         $display("FAIL flush_empty_done got=%b/%b expected=0/1", valid_out, ready_out);
      end
   endtask

   task automatic test_reset_mid();
      ready_in = 1;
      send(2'd3);
      send(2'd1);
      reset = 1;
      cycle();
      reset = 0;
      checks++;
      if (valid_out !== 0 || ready_out !== 1) begin
         failures++;
         $display("FAIL reset_mid_state got=%b/%b expected=0/1", valid_out, ready_out);
      end
      for (int i = 0; i < 4; i++) begin
         send(2'd2);
         checks++;
         if (valid_out !== (i == 3)) begin
            failures++;
            $display("FAIL reset_mid_valid i=%0d got=%b expected=%b", i, valid_out, i == 3);
         end
      end
      checks++;
      if (data_out !== 8'hAA || count_out !== 3'd4) begin
         failures++;
         $display("FAIL reset_mid_word got=%h/%0d expected=aa/4", data_out, count_out);
      end
      cycle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         valid_in = $urandom_range(0, 9) < 7;
         data_in  = 2'($urandom_range(0, 3));
         ready_in = $urandom_range(0, 9) < 6;
         flush    = $urandom_range(0, 19) == 0;
         cycle();
      end
      valid_in = 0;
      ready_in = 1;
      flush = 1;
      cycle();
      flush = 0;
      for (int i = 0; i < 10; i++) cycle();
      checks++;
      if (exp_w.size() != 0 || pend_q.size() != 0) begin
         failures++;
         $display("FAIL random_drain got=%0d words outstanding expected=0", exp_w.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_flush();
      test_flush_empty();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
